// File: rtl/int_to_float_if.sv
// Valid/ready bus carrying integer operands into the converter and fp32 results out of it.
interface int_to_float_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] debug;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, debug
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, debug
  );
endinterface

// File: rtl/int_to_float.sv
// Iterative 32-bit integer to fp32 converter: one-bit-per-cycle normalisation, then
// round-to-nearest-even, with valid/ready handshakes on both sides.
module int_to_float #(
  parameter bit IN_SIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  int_to_float_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic               out_valid_r, out_valid_nxt;
  logic        [31:0] out_data_r;
  logic        [5:0]  shift_cnt;
  logic               sign;
  logic        [31:0] mag;
  logic        [7:0]  expo;
  logic signed [31:0] in_s;
  logic               in_neg;
  logic        [31:0] in_mag;
  logic               accept;
  logic               shifting;

  // Round mag[30:8] to nearest-even; a carry out of the mantissa bumps the exponent.
  function automatic logic [31:0] round_rne(input logic s, input logic [7:0] e,
                                            input logic [30:0] m);
    logic        inc;
    logic [23:0] mant;
    inc  = m[7] & ((|m[6:0]) | m[8]);
    mant = {1'b0, m[30:8]} + {23'd0, inc};
    return {s, e + {7'd0, mant[23]}, mant[22:0]};
  endfunction

  assign in_s     = bus.in_data;
  assign in_neg   = IN_SIGNED && in_s[31];
  assign in_mag   = in_neg ? $unsigned(-in_s) : bus.in_data;
  assign accept   = (state == IDLE) && bus.in_valid;
  assign shifting = (state == NORM) && !mag[31];

  // A zero result enters DONE with out_valid low; it rises one edge later, and the
  // handshake only completes once out_valid has been presented.
  always_comb begin
    state_nxt     = state;
    out_valid_nxt = out_valid_r;
    case (state)
      IDLE:  if (bus.in_valid) state_nxt = (in_mag == '0) ? DONE : NORM;
      NORM:  if (mag[31]) state_nxt = ROUND;
      ROUND: begin
        state_nxt     = DONE;
        out_valid_nxt = 1'b1;
      end
      DONE: begin
        if (out_valid_r && bus.out_ready) begin
          state_nxt     = IDLE;
          out_valid_nxt = 1'b0;
        end else begin
          out_valid_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      shift_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      out_valid_r <= out_valid_nxt;
      if (accept) begin
        shift_cnt <= '0;
        if (in_mag == '0) out_data_r <= '0;
      end else if (shifting) begin
        shift_cnt <= shift_cnt + 6'd1;
      end else if (state == ROUND) begin
        out_data_r <= round_rne(sign, expo, mag[30:0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sign <= in_neg;
      mag  <= in_mag;
      expo <= 8'd158;
    end else if (shifting) begin
      mag  <= mag << 1;
      expo <= expo - 8'd1;
    end
  end

  assign bus.in_ready  = (state == IDLE) && reset;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.debug     = {24'd0, shift_cnt, state};

endmodule

// File: tb/tb_int_to_float.sv
// Bench for int_to_float: a signed and an unsigned instance, checked against a
// real-arithmetic fp32 reference with round-to-nearest-even.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        in_valid_t = 1'b0;
  logic [31:0] in_data_t = '0;
  logic        out_ready_t = 1'b1;
  int          checks = 0;
  int          failures = 0;

  int_to_float_if bus_s ();
  int_to_float_if bus_u ();

  int_to_float #(.IN_SIGNED(1'b1)) u_s (.clk(clk), .reset(reset), .bus(bus_s.slave));
  int_to_float #(.IN_SIGNED(1'b0)) u_u (.clk(clk), .reset(reset), .bus(bus_u.slave));

  always #5 clk = ~clk;

  assign bus_s.in_valid  = in_valid_t & ~sel;
  assign bus_u.in_valid  = in_valid_t & sel;
  assign bus_s.in_data   = in_data_t;
  assign bus_u.in_data   = in_data_t;
  assign bus_s.out_ready = out_ready_t;
  assign bus_u.out_ready = out_ready_t;

  wire        ir_o  = sel ? bus_u.in_ready  : bus_s.in_ready;
  wire        ov_o  = sel ? bus_u.out_valid : bus_s.out_valid;
  wire [31:0] od_o  = sel ? bus_u.out_data  : bus_s.out_data;
  wire [31:0] dbg_o = sel ? bus_u.debug     : bus_s.debug;

  // Exact integer value -> double -> fp32 with round-to-nearest-even.
  function automatic logic [31:0] ref_fp(input logic [31:0] din, input bit sgn);
    longint      x;
    logic [63:0] d;
    logic [7:0]  e;
    logic [23:0] keep;
    logic [28:0] rem;
    x = sgn ? longint'($signed(din)) : longint'({32'd0, din});
    if (x == 0) return 32'h0;
    d    = $realtobits(real'(x));
    e    = 8'(int'(d[62:52]) - 1023 + 127);
    keep = {1'b0, d[51:29]};
    rem  = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) keep = keep + 24'd1;
    if (keep[23]) e = e + 8'd1;
    return {d[63], e, keep[22:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] din, input bit sgn);
    longint      x;
    logic [63:0] m;
    x = sgn ? longint'($signed(din)) : longint'({32'd0, din});
    m = (x < 0) ? 64'(-x) : 64'(x);
    if (m == 0) return 1;
    for (int b = 31; b >= 0; b--) if (m[b]) return (31 - b) + 2;
    return 1;
  endfunction

  // Present one operand, then count edges until out_valid (bounded).
  task automatic convert(input logic [31:0] din, output logic [31:0] res,
                         output int lat, output logic [31:0] dbg);
    in_data_t  = din;
    in_valid_t = 1'b1;
    @(posedge clk); #1;
    in_valid_t = 1'b0;
    in_data_t  = $urandom;
    lat = 0;
    while (!ov_o && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    res = od_o;
    dbg = dbg_o;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus_s.out_valid !== 1'b0 || bus_s.out_data !== 32'h0 || bus_s.debug !== 32'h0) begin
      failures++;
      $display("FAIL reset_s: ov=%b od=%h dbg=%h required 0/0/0", bus_s.out_valid, bus_s.out_data, bus_s.debug);
    end
    checks++;
    if (bus_u.out_valid !== 1'b0 || bus_u.out_data !== 32'h0 || bus_u.debug !== 32'h0) begin
      failures++;
      $display("FAIL reset_u: ov=%b od=%h dbg=%h required 0/0/0", bus_u.out_valid, bus_u.out_data, bus_u.debug);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus_s.in_ready !== 1'b1 || bus_u.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: s=%b u=%b required 1", bus_s.in_ready, bus_u.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] din [7] = '{32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                             32'h01000001, 32'h01000003, 32'h00000000};
    logic [31:0] exp [7] = '{32'h3F800000, 32'hBF800000, 32'hCF000000, 32'h4F000000,
                             32'h4B800000, 32'h4B800002, 32'h00000000};
    int          lat_e [7] = '{33, 33, 2, 3, 9, 9, 1};
    logic [31:0] res, dbg, dbg_e;
    int          lat;
    sel = 1'b0;
    out_ready_t = 1'b1;
    for (int i = 0; i < 7; i++) begin
      convert(din[i], res, lat, dbg);
      dbg_e = {24'd0, 6'((lat_e[i] == 1) ? 0 : lat_e[i] - 2), 2'd3};
      checks++;
      if (res !== exp[i]) begin
        failures++;
        $display("FAIL directed_data in=%h: got %h required %h", din[i], res, exp[i]);
      end
      checks++;
      if (lat !== lat_e[i]) begin
        failures++;
        $display("FAIL directed_latency in=%h: got %0d required %0d", din[i], lat, lat_e[i]);
      end
      checks++;
      if (dbg !== dbg_e) begin
        failures++;
        $display("FAIL directed_debug in=%h: got %h required %h", din[i], dbg, dbg_e);
      end
      @(posedge clk); #1;
      checks++;
      if (ov_o !== 1'b0 || ir_o !== 1'b1) begin
        failures++;
        $display("FAIL directed_handshake in=%h: ov=%b ir=%b required 0/1", din[i], ov_o, ir_o);
      end
    end
  endtask

  task automatic test_random(input bit uns, input int n);
    logic [31:0] r, res, dbg, e;
    int          lat, le;
    sel = uns;
    out_ready_t = 1'b1;
    for (int i = 0; i < n; i++) begin
      r = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r = -r;
      if ($urandom_range(0, 15) == 0) r = 32'h0;
      if (uns && i == 0) r = 32'hFFFFFFFF;
      e  = ref_fp(r, !uns);
      le = ref_lat(r, !uns);
      convert(r, res, lat, dbg);
      checks++;
      if (res !== e || lat !== le) begin
        failures++;
        $display("FAIL random_%s in=%h: got %h lat %0d required %h lat %0d",
                 uns ? "u" : "s", r, res, lat, e, le);
      end
      @(posedge clk); #1;
    end
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] res, dbg, e;
    int          lat;
    sel = 1'b0;
    out_ready_t = 1'b0;
    convert(32'h00123457, res, lat, dbg);
    e = ref_fp(32'h00123457, 1'b1);
    checks++;
    if (res !== e) begin
      failures++;
      $display("FAIL bp_data: got %h required %h", res, e);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid_t = 1'b1;
      in_data_t  = $urandom;
      @(posedge clk); #1;
      checks++;
      if (ov_o !== 1'b1 || od_o !== e || ir_o !== 1'b0 || dbg_o[1:0] !== 2'd3) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: ov=%b od=%h ir=%b st=%0d required 1/%h/0/3",
                 i, ov_o, od_o, ir_o, dbg_o[1:0], e);
      end
    end
    in_valid_t  = 1'b0;
    out_ready_t = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov_o !== 1'b0 || ir_o !== 1'b1 || dbg_o[1:0] !== 2'd0) begin
      failures++;
      $display("FAIL bp_release: ov=%b ir=%b st=%0d required 0/1/0", ov_o, ir_o, dbg_o[1:0]);
    end
    convert(32'hFFFF0001, res, lat, dbg);
    e = ref_fp(32'hFFFF0001, 1'b1);
    checks++;
    if (res !== e) begin
      failures++;
      $display("FAIL bp_next: got %h required %h", res, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res, dbg, e;
    int          lat;
    sel = 1'b0;
    out_ready_t = 1'b1;
    in_data_t  = 32'h00000001;
    in_valid_t = 1'b1;
    @(posedge clk); #1;
    in_valid_t = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (ov_o !== 1'b0 || dbg_o !== 32'h0 || od_o !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset: ov=%b dbg=%h od=%h required 0/0/0", ov_o, dbg_o, od_o);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir_o !== 1'b1 || dbg_o !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset_release: ir=%b dbg=%h required 1/0", ir_o, dbg_o);
    end
    convert(32'hC0000001, res, lat, dbg);
    e = ref_fp(32'hC0000001, 1'b1);
    checks++;
    if (res !== e || lat !== ref_lat(32'hC0000001, 1'b1)) begin
      failures++;
      $display("FAIL mid_reset_next: got %h lat %0d required %h lat %0d",
               res, lat, e, ref_lat(32'hC0000001, 1'b1));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(1'b0, 40);
    test_random(1'b1, 15);
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
